// File: rtl/fic2_apb_timer_slave.sv
// APB3 completer for FIC_2_APB_M: ID/CTRL/STATUS/LOAD/COUNT/SCRATCH registers plus a prescaled 32-bit down-counter timer.
// Build option: define FIC2_APB_PSLVERR_EN to answer unmapped offsets with PSLVERR=1.
module fic2_apb_timer_slave #(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hF2A0_0001
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              TIMER_IRQ
);

  localparam int         OFF_W = ADDR_W - 2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

  state_t           state;
  logic [3:0]       wcnt;
  logic             go_access;
  logic [OFF_W-1:0] off;
  logic [31:0]      rd_data;

  logic        ctrl_en, irq_en, exp;
  logic [7:0]  prescale, psc;
  logic [31:0] load, count, scratch;
  logic        wr, wr_ctrl, wr_status, wr_load, wr_scratch;
  logic        en_rise, tick, expire;

  // Byte-lane bits of PADDR carry no meaning for word registers.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^PADDR[1:0];

  assign off = PADDR[ADDR_W-1:2];

  // PREADY is registered, so the decision to complete is taken one cycle early.
  always_comb begin
    go_access = 1'b0;
    case (state)
      ST_IDLE: go_access = PSEL && !PENABLE && (WAIT_STATES == 0);
      ST_WAIT: go_access = PSEL && PENABLE && (wcnt == WS - 4'd1);
      default: go_access = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_W'(0): rd_data = ID_VALUE;
      OFF_W'(1): rd_data = {16'b0, prescale, 6'b0, irq_en, ctrl_en};
      OFF_W'(2): rd_data = {31'b0, exp};
      OFF_W'(3): rd_data = load;
      OFF_W'(4): rd_data = count;
      OFF_W'(5): rd_data = scratch;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      PREADY <= go_access;
      PRDATA <= (go_access && !PWRITE) ? rd_data : '0;
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            wcnt  <= '0;
            state <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!PSEL)
            state <= ST_IDLE;
          else if (go_access)
            state <= ST_ACCESS;
          else if (PENABLE)
            wcnt <= wcnt + 4'd1;
        end
        ST_ACCESS: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign wr         = PSEL && PENABLE && PWRITE && PREADY;
  assign wr_ctrl    = wr && (off == OFF_W'(1));
  assign wr_status  = wr && (off == OFF_W'(2));
  assign wr_load    = wr && (off == OFF_W'(3));
  assign wr_scratch = wr && (off == OFF_W'(5));

  assign en_rise = wr_ctrl && PWDATA[0] && !ctrl_en;
  // >= keeps the prescaler from running through 255 if PRESCALE shrinks while enabled.
  assign tick    = ctrl_en && (psc >= prescale);
  assign expire  = tick && (count == 32'd0);

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      ctrl_en  <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      load     <= '0;
      scratch  <= '0;
      count    <= '0;
      psc      <= '0;
      exp      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en  <= PWDATA[0];
        irq_en   <= PWDATA[1];
        prescale <= PWDATA[15:8];
      end
      if (wr_load)    load    <= PWDATA;
      if (wr_scratch) scratch <= PWDATA;
      if (en_rise) begin
        count <= load;
        psc   <= '0;
      end else if (tick) begin
        psc   <= '0;
        count <= (count == 32'd0) ? load : count - 32'd1;
      end else if (ctrl_en) begin
        psc <= psc + 8'd1;
      end
      // A same-cycle expiry beats the write-one-to-clear.
      exp <= expire || (exp && !(wr_status && PWDATA[0]));
    end
  end

  assign TIMER_IRQ = exp && irq_en;

`ifdef FIC2_APB_PSLVERR_EN
  logic pslverr_q;
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) pslverr_q <= 1'b0;
    else           pslverr_q <= go_access && (off > OFF_W'(5));
  end
  assign PSLVERR = pslverr_q;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule
